// File: rtl/uart_alu_host.sv
// uart_alu_host: UART-ALU link initiator. Serialises A, B, {0,opcode} to a UART TX byte port and
// returns the single result byte from UART RX. Define UART_ALU_HOST_RETRY_EN to re-send on a result timeout.
module uart_alu_host #(
  parameter int unsigned SIZEDATA       = 8,
  parameter int unsigned SIZEOP         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [SIZEDATA-1:0] i_datoa,
  input  logic [SIZEDATA-1:0] i_datob,
  input  logic [SIZEOP-1:0]   i_opcode,
  input  logic                i_tx_done,
  input  logic                i_rx_done,
  input  logic [SIZEDATA-1:0] i_rx_data,
  output logic [SIZEDATA-1:0] o_tx_data,
  output logic                o_tx_signal,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_timeout,
  output logic [SIZEDATA-1:0] o_result
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_TX = 3'd2,
    WAIT_RX = 3'd3,
    FINISH  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [SIZEDATA-1:0] a_q, a_d;
  logic [SIZEDATA-1:0] b_q, b_d;
  logic [SIZEDATA-1:0] op_q, op_d;
  logic [1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SIZEDATA-1:0] tx_data_q, tx_data_d;
  logic                tx_signal_q, tx_signal_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic [SIZEDATA-1:0] result_q, result_d;

  logic [CNT_W-1:0]    cnt_inc;
  logic                cnt_hit;

`ifdef UART_ALU_HOST_RETRY_EN
  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RTY_W-1:0] retry_q, retry_d;
`else
  localparam int unsigned unused_max_retry = MAX_RETRY;
`endif

  // Wait-state budget: abort decided on the cycle the count would reach TIMEOUT_CYCLES
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign cnt_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      tx_signal_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      result_q    <= '0;
`ifdef UART_ALU_HOST_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_signal_q <= tx_signal_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      result_q    <= result_d;
`ifdef UART_ALU_HOST_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  // Outputs are computed on the transition into a state so the pulse lands in that state's cycle
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    tx_signal_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    result_d    = result_q;
`ifdef UART_ALU_HOST_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d         = i_datoa;
          b_d         = i_datob;
          op_d        = SIZEDATA'(i_opcode);
          idx_d       = 2'd0;
          busy_d      = 1'b1;
          tx_data_d   = i_datoa;
          tx_signal_d = 1'b1;
          state_d     = SEND;
`ifdef UART_ALU_HOST_RETRY_EN
          retry_d     = '0;
`endif
        end
      end

      SEND: begin
        cnt_d   = '0;
        state_d = WAIT_TX;
      end

      WAIT_TX: begin
        if (i_tx_done) begin
          idx_d = idx_q + 2'd1;
          cnt_d = '0;
          if (idx_q == 2'd2) begin
            state_d = WAIT_RX;
          end else begin
            tx_data_d   = (idx_q == 2'd0) ? b_q : op_q;
            tx_signal_d = 1'b1;
            state_d     = SEND;
          end
        end else if (cnt_hit) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_RX: begin
        if (i_rx_done) begin
          result_d = i_rx_data;
          state_d  = FINISH;
        end else if (cnt_hit) begin
`ifdef UART_ALU_HOST_RETRY_EN
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            // Lost reply: replay the whole frame from operand A
            retry_d     = retry_q + RTY_W'(1);
            idx_d       = 2'd0;
            cnt_d       = '0;
            tx_data_d   = a_q;
            tx_signal_d = 1'b1;
            state_d     = SEND;
          end else begin
            done_d    = 1'b1;
            timeout_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end
`else
          done_d    = 1'b1;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end

      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_signal = tx_signal_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_timeout   = timeout_q;
  assign o_result    = result_q;

endmodule
